// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing a single-port data memory between fetch (A) and load/store (B).
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
   parameter int DEPTH      = 32,
   parameter int STARVE_MAX = 4
`ifdef DMEM_ARB_STATS_EN
   ,
   parameter int CNT_W      = 16
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req_valid,
   input  logic [31:0] a_req_addr,
   output logic        a_req_ready,
   output logic        a_rsp_valid,
   output logic [31:0] a_rsp_rdata,
   output logic        a_rsp_err,
   input  logic        b_req_valid,
   input  logic        b_req_we,
   input  logic [31:0] b_req_addr,
   input  logic [31:0] b_req_wdata,
   output logic        b_req_ready,
   output logic        b_rsp_valid,
   output logic [31:0] b_rsp_rdata,
   output logic        b_rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_conflicts,
   output logic [CNT_W-1:0] stat_a_stalls,
   output logic [CNT_W-1:0] stat_starve_wins
`endif
);

   logic        starved, grant_a, grant_b, a_in_rng, b_in_rng;
   logic [3:0]  starve_cnt_d, starve_cnt_q;
   logic        a_rsp_valid_d, a_rsp_valid_q, a_rsp_err_d, a_rsp_err_q;
   logic        b_rsp_valid_d, b_rsp_valid_q, b_rsp_err_d, b_rsp_err_q;
   logic [31:0] a_rsp_rdata_d, a_rsp_rdata_q, b_rsp_rdata_d, b_rsp_rdata_q;

   always_comb begin
      starved  = (starve_cnt_q == 4'(STARVE_MAX));
      a_in_rng = (a_req_addr < 32'(DEPTH));
      b_in_rng = (b_req_addr < 32'(DEPTH));

      // Grants are suppressed while rst is held so no access escapes during reset.
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst) begin
         if (a_req_valid && (!b_req_valid || starved)) grant_a = 1'b1;
         else if (b_req_valid)                         grant_b = 1'b1;
      end

      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (grant_a) begin
         mem_addr = a_req_addr;
         mem_re   = a_in_rng;
      end else if (grant_b) begin
         mem_addr  = b_req_addr;
         mem_wdata = b_req_wdata;
         mem_we    = b_req_we & b_in_rng;
         mem_re    = ~b_req_we & b_in_rng;
      end

      starve_cnt_d = '0;
      if (a_req_valid && !grant_a)
         starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 4'd1;

      a_rsp_valid_d = grant_a;
      a_rsp_err_d   = grant_a & ~a_in_rng;
      a_rsp_rdata_d = (grant_a && a_in_rng) ? mem_rdata : '0;
      b_rsp_valid_d = grant_b;
      b_rsp_err_d   = grant_b & ~b_in_rng;
      b_rsp_rdata_d = (grant_b && !b_req_we && b_in_rng) ? mem_rdata : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q  <= '0;
         a_rsp_valid_q <= 1'b0;
         a_rsp_err_q   <= 1'b0;
         a_rsp_rdata_q <= '0;
         b_rsp_valid_q <= 1'b0;
         b_rsp_err_q   <= 1'b0;
         b_rsp_rdata_q <= '0;
      end else begin
         starve_cnt_q  <= starve_cnt_d;
         a_rsp_valid_q <= a_rsp_valid_d;
         a_rsp_err_q   <= a_rsp_err_d;
         a_rsp_rdata_q <= a_rsp_rdata_d;
         b_rsp_valid_q <= b_rsp_valid_d;
         b_rsp_err_q   <= b_rsp_err_d;
         b_rsp_rdata_q <= b_rsp_rdata_d;
      end
   end

   assign a_req_ready = grant_a;
   assign b_req_ready = grant_b;
   assign a_rsp_valid = a_rsp_valid_q;
   assign a_rsp_rdata = a_rsp_rdata_q;
   assign a_rsp_err   = a_rsp_err_q;
   assign b_rsp_valid = b_rsp_valid_q;
   assign b_rsp_rdata = b_rsp_rdata_q;
   assign b_rsp_err   = b_rsp_err_q;

`ifdef DMEM_ARB_STATS_EN
   logic [CNT_W-1:0] stat_conflicts_d, stat_conflicts_q;
   logic [CNT_W-1:0] stat_a_stalls_d, stat_a_stalls_q;
   logic [CNT_W-1:0] stat_starve_wins_d, stat_starve_wins_q;

   always_comb begin
      stat_conflicts_d   = stat_conflicts_q;
      stat_a_stalls_d    = stat_a_stalls_q;
      stat_starve_wins_d = stat_starve_wins_q;
      if (a_req_valid && b_req_valid && stat_conflicts_q != '1)
         stat_conflicts_d = stat_conflicts_q + 1'b1;
      if (a_req_valid && !grant_a && stat_a_stalls_q != '1)
         stat_a_stalls_d = stat_a_stalls_q + 1'b1;
      // A starvation win is an A grant that B would otherwise have taken.
      if (grant_a && b_req_valid && starved && stat_starve_wins_q != '1)
         stat_starve_wins_d = stat_starve_wins_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_conflicts_q   <= '0;
         stat_a_stalls_q    <= '0;
         stat_starve_wins_q <= '0;
      end else begin
         stat_conflicts_q   <= stat_conflicts_d;
         stat_a_stalls_q    <= stat_a_stalls_d;
         stat_starve_wins_q <= stat_starve_wins_d;
      end
   end

   assign stat_conflicts   = stat_conflicts_q;
   assign stat_a_stalls    = stat_a_stalls_q;
   assign stat_starve_wins = stat_starve_wins_q;
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: port A (instruction fetch, read-only) and port B (MEM-stage load/store).
- Grants at most one access per cycle and drives the memory's address, write-data, write-enable and read-enable pins.
- Returns each response one cycle after grant from a registered output stage.
- Default priority goes to port B (older instruction). A starvation counter forces port A through when it has waited too long.

Parameters:
- DEPTH, 32: memory depth in words. Addresses >= DEPTH are out of range.
- STARVE_MAX, 4: consecutive denied cycles of port A after which A takes priority. Legal range 1..15.
- CNT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req_valid  in  1  fetch request.
- a_req_addr  in  32  fetch word address.
- a_req_ready  out  1  fetch request accepted this cycle (combinational).
- a_rsp_valid  out  1  fetch response valid.
- a_rsp_rdata  out  32  fetch read data.
- a_rsp_err  out  1  out-of-range access.
- b_req_valid  in  1  load/store request.
- b_req_we  in  1  1 = store, 0 = load.
- b_req_addr  in  32  word address.
- b_req_wdata  in  32  store data.
- b_req_ready  out  1  load/store request accepted this cycle.
- b_rsp_valid  out  1  load/store response (load data or store ack).
- b_rsp_rdata  out  32  load data (0 for stores).
- b_rsp_err  out  1  out-of-range access.
- mem_addr  out  32  memory word address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  32  memory read data, combinational from mem_addr while mem_re is high.

Behaviour:
- Grant rule, combinational each cycle:
  - If only one requester is valid, it is granted.
  - If both are valid and starve_cnt == STARVE_MAX, A is granted; otherwise B is granted.
  - a_req_ready = grant_a; b_req_ready = grant_b. Exactly zero or one grant per cycle.
- Memory drive:
  - The granted request's address goes to mem_addr.
  - mem_re = grant_a | (grant_b & ~b_req_we).
  - mem_we = grant_b & b_req_we; mem_wdata = b_req_wdata.
  - With no grant, mem_re, mem_we, mem_addr and mem_wdata are all 0.
- Out-of-range access (addr >= DEPTH):
  - The request is still granted (ready = 1), but mem_re and mem_we are forced to 0.
  - The response has err = 1 and rdata = 0.
- Starvation counter starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, when a_req_valid & ~grant_a.
  - Cleared when grant_a or ~a_req_valid.
- Response stage, registered at posedge after a grant:
  - x_rsp_valid = 1.
  - x_rsp_rdata = mem_rdata sampled in the grant cycle; 0 for stores and errors.
  - x_rsp_err as defined above.
  - rsp_valid is a one-cycle pulse. Responses cannot be back-pressured; requesters must accept them.
- Latency: request accepted in cycle N, response in cycle N+1. Back-to-back grants to the same port give back-to-back responses.
- A store followed next cycle by a load to the same address returns the new data, because the memory write commits at the grant-cycle edge.
- Reset, asynchronous:
  - Clears starve_cnt, all rsp_valid, rsp_rdata and rsp_err to 0.
  - Outputs during reset: a_req_ready = 0, b_req_ready = 0, mem_we = 0, mem_re = 0.
  - A request in flight when reset asserts is dropped and produces no response after reset.
- A requester whose valid deasserts without a grant is legal; that request is simply withdrawn.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds the following, each CNT_W wide, saturating, cleared by rst:
  - Output stat_conflicts: cycles with both requesters valid.
  - Output stat_a_stalls: cycles A was valid but not granted.
  - Output stat_starve_wins: grants to A caused by starve_cnt == STARVE_MAX.
- When not defined, these ports and registers do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then A reads addr 3 alone (mem holds 0x0000_1234): a_req_ready = 1 in the same cycle; next cycle a_rsp_valid = 1, a_rsp_rdata = 0x0000_1234, a_rsp_err = 0.
- B stores 0xDEAD_BEEF to addr 5 in cycle N, then loads addr 5 in cycle N+1: store ack at N+1 with rdata = 0; load response at N+2 with rdata = 0xDEAD_BEEF.
- Both A and B valid continuously, STARVE_MAX = 4: B granted 4 cycles, A granted on the 5th, then the pattern repeats; no cycle has both readies high.
- A reads addr 32 (DEPTH = 32): a_req_ready = 1, mem_re = 0; next cycle a_rsp_err = 1, a_rsp_rdata = 0. A B store to addr 40 causes no memory write.
- Assert rst in the cycle after a B grant: b_rsp_valid is 0 at and after reset; no response appears once rst releases.
- With DMEM_ARB_STATS_EN and the 10-cycle contention run above: stat_conflicts = 10, stat_a_stalls = 8, stat_starve_wins = 2.
